// File: rtl/query_patch_loader_pkg.sv
// Shared constants and types for the query-patch loader.
// Default widths match the query-patch SRAM macro.
package query_patch_loader_pkg;

  localparam int unsigned QPL_DATA_WIDTH = 11;
  localparam int unsigned QPL_PATCH_SIZE = 5;
  localparam int unsigned QPL_MEM_WIDTH  = 56;
  localparam int unsigned QPL_ADDR_WIDTH = 9;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StWrite,
    StDone
  } loader_state_e;

endpackage

// File: rtl/query_patch_loader_patch_packer.sv
// Packs PATCH_SIZE FIFO words into one patch, word 0 in the LSBs.
// patch_next exposes the register's next value so a completed patch can be captured on its last push.
module query_patch_loader_patch_packer
  import query_patch_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = QPL_DATA_WIDTH,
  parameter int unsigned PATCH_SIZE = QPL_PATCH_SIZE
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             push,
  input  logic [DATA_WIDTH-1:0]            word,
  output logic                             full,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] patch_next
);

  localparam int unsigned IdxW = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PATCH_SIZE - 1);

  logic [IdxW-1:0]                       idx_q, idx_d;
  logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] words_q, words_d;

  always_comb begin
    idx_d   = idx_q;
    words_d = words_q;
    if (clear) begin
      idx_d   = '0;
      words_d = '0;
    end else if (push) begin
      // First word of a patch wipes the previous patch so stale words never leak.
      if (idx_q == '0) begin
        words_d = '0;
      end
      words_d[idx_q] = word;
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end
  end

  assign full       = push && !clear && (idx_q == LastIdx);
  assign patch_next = words_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      words_q <= '0;
    end else begin
      idx_q   <= idx_d;
      words_q <= words_d;
    end
  end

endmodule

// File: rtl/query_patch_loader.sv
// Dequeues FIFO words, packs them into query patches and writes each patch to the query SRAM.
// All outputs except fifo_deq are registered from the next state.
module query_patch_loader
  import query_patch_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = QPL_DATA_WIDTH,
  parameter int unsigned PATCH_SIZE = QPL_PATCH_SIZE,
  parameter int unsigned MEM_WIDTH  = QPL_MEM_WIDTH,
  parameter int unsigned ADDR_WIDTH = QPL_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_patches,
  input  logic                  fifo_rempty_n,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_deq,
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [MEM_WIDTH-1:0]  mem_wpatch0,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned PackW = DATA_WIDTH * PATCH_SIZE;
  localparam int unsigned CntW  = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0] MaxPatches = {1'b1, {ADDR_WIDTH{1'b0}}};

  loader_state_e   state_q, state_d;
  logic [CntW-1:0] total_q, total_d;
  logic [CntW-1:0] patch_cnt_q, patch_cnt_d;
  logic            deq;
  logic            pack_clear;
  logic            pack_full;
  logic [PackW-1:0]     pack_next;
  logic [MEM_WIDTH-1:0] wpatch_ext;

  query_patch_loader_patch_packer #(
    .DATA_WIDTH(DATA_WIDTH),
    .PATCH_SIZE(PATCH_SIZE)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pack_clear),
    .push      (deq),
    .word      (fifo_rdata),
    .full      (pack_full),
    .patch_next(pack_next)
  );

  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    patch_cnt_d = patch_cnt_q;
    pack_clear  = 1'b0;
    deq         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          total_d     = (num_patches > MaxPatches) ? MaxPatches : num_patches;
          patch_cnt_d = '0;
          pack_clear  = 1'b1;
          state_d     = (num_patches == '0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        deq = fifo_rempty_n;
        if (pack_full) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        patch_cnt_d = patch_cnt_q + 1'b1;
        state_d     = (patch_cnt_d == total_q) ? StDone : StFetch;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    wpatch_ext             = '0;
    wpatch_ext[PackW-1:0]  = pack_next;
  end

  assign fifo_deq = deq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      total_q     <= '0;
      patch_cnt_q <= '0;
      mem_csb0    <= 1'b1;
      mem_web0    <= 1'b1;
      mem_addr0   <= '0;
      mem_wpatch0 <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      patch_cnt_q <= patch_cnt_d;
      busy        <= (state_d == StFetch) || (state_d == StWrite);
      done        <= (state_d == StDone);
      mem_csb0    <= (state_d != StWrite);
      mem_web0    <= (state_d != StWrite);
      // Address and data are captured on entry to WRITE and then hold until the next patch.
      if (state_d == StWrite) begin
        mem_addr0   <= patch_cnt_q[ADDR_WIDTH-1:0];
        mem_wpatch0 <= wpatch_ext;
      end
    end
  end

endmodule

// File: tb/tb_query_patch_loader.sv
// Bench for query_patch_loader: FIFO model, write/done monitor, table of loads and corner sequences.
module tb_query_patch_loader;

  localparam int unsigned DW = 11;
  localparam int unsigned PS = 5;
  localparam int unsigned MW = 56;
  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_patches = '0;
  logic          fifo_rempty_n;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_deq;
  logic          mem_csb0, mem_web0;
  logic [AW-1:0] mem_addr0;
  logic [MW-1:0] mem_wpatch0;
  logic          busy, done;

  query_patch_loader #(
    .DATA_WIDTH(DW),
    .PATCH_SIZE(PS),
    .MEM_WIDTH (MW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_patches  (num_patches),
    .fifo_rempty_n(fifo_rempty_n),
    .fifo_rdata   (fifo_rdata),
    .fifo_deq     (fifo_deq),
    .mem_csb0     (mem_csb0),
    .mem_web0     (mem_web0),
    .mem_addr0    (mem_addr0),
    .mem_wpatch0  (mem_wpatch0),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // First-word-fall-through FIFO model.
  logic [DW-1:0] fmem [0:8191];
  int unsigned   wr_cnt = 0;
  int unsigned   rd_ptr = 0;
  logic          flush = 1'b0;

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_cnt;
    else if (fifo_deq) rd_ptr <= rd_ptr + 1;
  end
  assign fifo_rempty_n = (rd_ptr < wr_cnt);
  assign fifo_rdata    = fmem[rd_ptr[12:0]];

  // Monitor, sampled on the falling edge.
  int unsigned cyc = 0;
  int unsigned deq_cnt = 0;
  int unsigned bad_deq = 0;
  int unsigned     wr_addr_q[$];
  logic [63:0]     wr_data_q[$];
  int unsigned     wr_cyc_q[$];
  int unsigned     done_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_deq) deq_cnt <= deq_cnt + 1;
    if (fifo_deq && !fifo_rempty_n) bad_deq <= bad_deq + 1;
    if (!mem_csb0 && !mem_web0) begin
      wr_addr_q.push_back(32'(mem_addr0));
      wr_data_q.push_back(64'(mem_wpatch0));
      wr_cyc_q.push_back(cyc);
    end
    if (done) done_cyc_q.push_back(cyc);
  end

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [DW-1:0] exp_words[$];

  typedef struct {
    int unsigned n;
    int unsigned pattern;    // 0: incrementing from base, 1: random
    int unsigned base;
    int unsigned exp_writes;
    int unsigned exp_deqs;
    int unsigned exp_done_delay;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fmem[wr_cnt[12:0]] = w;
    wr_cnt++;
    exp_words.push_back(w);
  endtask

  task automatic flush_fifo();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_words.delete();
  endtask

  task automatic pulse_start(input int unsigned n, output int unsigned st);
    start       = 1'b1;
    num_patches = (AW + 1)'(n);
    st          = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned b_done, input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(budget); i++) begin
      tick();
      if (done_cyc_q.size() > b_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_deqs(input int unsigned b, input int unsigned target,
                           input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < int'(budget); i++) begin
      if (deq_cnt - b >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Reference: patch p is words 5p..5p+4 of the pushed stream, word 0 in the LSBs.
  function automatic logic [63:0] model_patch(input int unsigned p);
    logic [63:0] e = '0;
    for (int k = 0; k < int'(PS); k++)
      e = e | (64'(exp_words[p * PS + k]) << (DW * k));
    return e;
  endfunction

  task automatic check_writes(input string tag, input int unsigned b_wr, input int unsigned nexp,
                              input int unsigned st, input bit timing);
    int unsigned got = wr_addr_q.size() - b_wr;
    for (int unsigned k = 0; k < nexp && k < got; k++) begin
      check({tag, " addr"}, 64'(wr_addr_q[b_wr + k]), 64'(k));
      check({tag, " data"}, wr_data_q[b_wr + k], model_patch(k));
      if (timing) check({tag, " write cycle"}, 64'(wr_cyc_q[b_wr + k] - st), 64'(6 * (k + 1)));
    end
  endtask

  task automatic run_row(input vec_t r, input int idx);
    int unsigned b_wr, b_done, b_deq, st;
    bit ok;
    string tag;
    tag = $sformatf("row%0d", idx);
    flush_fifo();
    for (int unsigned i = 0; i < r.exp_deqs; i++)
      push_word((r.pattern == 0) ? DW'(r.base + i) : DW'($urandom));
    b_wr   = wr_addr_q.size();
    b_done = done_cyc_q.size();
    b_deq  = deq_cnt;
    pulse_start(r.n, st);
    wait_done(b_done, r.exp_done_delay + 40, ok);
    check({tag, " done seen"}, 64'(ok), 64'(1));
    if (ok) check({tag, " done delay"}, 64'(done_cyc_q[b_done] - st), 64'(r.exp_done_delay));
    check({tag, " busy after done"}, 64'(busy), 64'(0));
    repeat (3) tick();
    check({tag, " done count"}, 64'(done_cyc_q.size() - b_done), 64'(ok ? 1 : 0));
    check({tag, " write count"}, 64'(wr_addr_q.size() - b_wr), 64'(r.exp_writes));
    check({tag, " deq count"}, 64'(deq_cnt - b_deq), 64'(r.exp_deqs));
    check_writes(tag, b_wr, r.exp_writes, st, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " fifo_deq"}, 64'(fifo_deq), 64'(0));
    check({tag, " mem_csb0"}, 64'(mem_csb0), 64'(1));
    check({tag, " mem_web0"}, 64'(mem_web0), 64'(1));
    check({tag, " mem_addr0"}, 64'(mem_addr0), 64'(0));
    check({tag, " mem_wpatch0"}, 64'(mem_wpatch0), 64'(0));
    check({tag, " busy"}, 64'(busy), 64'(0));
    check({tag, " done"}, 64'(done), 64'(0));
  endtask

  initial begin
    int unsigned b_wr, b_done, b_deq, st, st2;
    bit ok;

    tbl[0] = '{1,   0, 1, 1,   5,    7};
    tbl[1] = '{3,   0, 0, 3,   15,   19};
    tbl[2] = '{0,   0, 0, 0,   0,    1};
    tbl[3] = '{4,   1, 0, 4,   20,   25};
    tbl[4] = '{2,   1, 0, 2,   10,   13};
    tbl[5] = '{512, 1, 0, 512, 2560, 3073};
    tbl[6] = '{700, 1, 0, 512, 2560, 3073};

    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_row(tbl[i], i);

    // Stall: FIFO runs dry after word 3, refilled 10 cycles later.
    flush_fifo();
    for (int i = 0; i < 3; i++) push_word(DW'($urandom));
    b_wr   = wr_addr_q.size();
    b_done = done_cyc_q.size();
    b_deq  = deq_cnt;
    pulse_start(2, st);
    wait_deqs(b_deq, 3, 20, ok);
    check("stall first words", 64'(ok), 64'(1));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall fifo_deq", 64'(fifo_deq), 64'(0));
      check("stall mem_csb0", 64'(mem_csb0), 64'(1));
    end
    check("stall busy", 64'(busy), 64'(1));
    for (int i = 0; i < 7; i++) push_word(DW'($urandom));
    wait_done(b_done, 60, ok);
    check("stall done seen", 64'(ok), 64'(1));
    check("stall write count", 64'(wr_addr_q.size() - b_wr), 64'(2));
    check_writes("stall", b_wr, 2, st, 1'b0);

    // Restart ignored mid-load, then reset inside patch 1.
    flush_fifo();
    for (int unsigned i = 0; i < 10; i++) push_word(DW'(12'h100 + i));
    b_wr   = wr_addr_q.size();
    b_done = done_cyc_q.size();
    b_deq  = deq_cnt;
    pulse_start(2, st);
    repeat (2) tick();
    pulse_start(1, st2);
    wait_deqs(b_deq, 7, 30, ok);
    check("midload deqs reached", 64'(ok), 64'(1));
    tick();
    check("midload writes before reset", 64'(wr_addr_q.size() - b_wr), 64'(1));
    check_writes("midload", b_wr, 1, st, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) tick();
    check("midload no partial write", 64'(wr_addr_q.size() - b_wr), 64'(1));
    check("midload no done", 64'(done_cyc_q.size() - b_done), 64'(0));
    rst_n = 1'b1;
    tick();
    flush_fifo();
    for (int i = 0; i < 5; i++) push_word(DW'($urandom));
    b_wr   = wr_addr_q.size();
    b_done = done_cyc_q.size();
    pulse_start(1, st);
    wait_done(b_done, 40, ok);
    check("post-reset done seen", 64'(ok), 64'(1));
    check("post-reset write count", 64'(wr_addr_q.size() - b_wr), 64'(1));
    check_writes("post-reset", b_wr, 1, st, 1'b1);

    check("deq while empty", 64'(bad_deq), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
